// File: rtl/stage_phase_accumulator_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : stage_phase_accumulator_pkg
//  Purpose   : Shared sizes and types for the phase accumulator stage.
//  Revision  : 1.0  initial release
// ============================================================================
package stage_phase_accumulator_pkg;

    localparam int NUM_VOICE_OPERATORS = 16;
    localparam int VOICE_OPERATOR_ID_WIDTH = $clog2(NUM_VOICE_OPERATORS);
    localparam int PHASE_ACC_WIDTH = 24;
    localparam int PHASE_OUT_WIDTH = 16;
    localparam int FREQ_STEP_WIDTH = 16;

    typedef logic [VOICE_OPERATOR_ID_WIDTH-1:0] VoiceOperatorID_t;
    typedef logic [FREQ_STEP_WIDTH-1:0]         FrequencyStep_t;
    typedef logic [PHASE_ACC_WIDTH-1:0]         PhaseAcc_t;
    typedef logic [PHASE_OUT_WIDTH-1:0]         Phase_t;

    localparam VoiceOperatorID_t LAST_SLOT = VoiceOperatorID_t'(NUM_VOICE_OPERATORS - 1);

    // The step occupies the low bits of the accumulator; the top bits only carry.
    function automatic PhaseAcc_t f_ExtendStep(input FrequencyStep_t i_Step);
        return {{(PHASE_ACC_WIDTH - FREQ_STEP_WIDTH){1'b0}}, i_Step};
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_phase_accumulator_slot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module    : stage_phase_accumulator_slot_sequencer
//  Purpose   : Round-robin slot counter with the matching valid/ID pipeline.
//  Revision  : 1.0  initial release
// ============================================================================
module stage_phase_accumulator_slot_sequencer
    import stage_phase_accumulator_pkg::*;
(
    input  logic             i_Clock,
    input  logic             i_Reset,
    output VoiceOperatorID_t o_ReadSlot,
    output logic             o_S1Valid,
    output VoiceOperatorID_t o_S1Slot,
    output logic             o_Valid,
    output VoiceOperatorID_t o_VoiceOperator,
    output logic             o_SampleStart
);

    VoiceOperatorID_t r_Counter;
    logic             r_S1Valid;
    VoiceOperatorID_t r_S1Slot;
    logic             r_OutValid;
    VoiceOperatorID_t r_OutSlot;
    logic             r_OutSampleStart;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Counter        <= '0;
            r_S1Valid        <= 1'b0;
            r_S1Slot         <= '0;
            r_OutValid       <= 1'b0;
            r_OutSlot        <= '0;
            r_OutSampleStart <= 1'b0;
        end else begin
            r_Counter        <= (r_Counter == LAST_SLOT) ? '0 : r_Counter + 1'b1;
            r_S1Valid        <= 1'b1;
            r_S1Slot         <= r_Counter;
            r_OutValid       <= r_S1Valid;
            r_OutSlot        <= r_S1Slot;
            r_OutSampleStart <= r_S1Valid && (r_S1Slot == '0);
        end
    end

    assign o_ReadSlot      = r_Counter;
    assign o_S1Valid       = r_S1Valid;
    assign o_S1Slot        = r_S1Slot;
    assign o_Valid         = r_OutValid;
    assign o_VoiceOperator = r_OutSlot;
    assign o_SampleStart   = r_OutSampleStart;

endmodule
`default_nettype wire

// File: rtl/stage_phase_accumulator.sv
`default_nettype none
// ============================================================================
//  Module    : stage_phase_accumulator
//  Purpose   : Per-operator phase accumulators swept once per sample period.
//  Revision  : 1.0  initial release
// ============================================================================
module stage_phase_accumulator
    import stage_phase_accumulator_pkg::*;
(
    input  logic             i_Clock,
    input  logic             i_Reset,
    output logic             o_Valid,
    output Phase_t           o_Phase,
    output VoiceOperatorID_t o_VoiceOperator,
    output logic             o_SampleStart,
    input  logic [1:0]       i_FrequencyWriteEnable,
    input  VoiceOperatorID_t i_FrequencyWriteAddr,
    input  logic [7:0]       i_FrequencyWriteData,
    input  logic             i_PhaseResetEnable,
    input  VoiceOperatorID_t i_PhaseResetAddr
);

    VoiceOperatorID_t w_ReadSlot;
    logic             w_S1Valid;
    VoiceOperatorID_t w_S1Slot;

    stage_phase_accumulator_slot_sequencer u_slot_sequencer (
        .i_Clock         (i_Clock),
        .i_Reset         (i_Reset),
        .o_ReadSlot      (w_ReadSlot),
        .o_S1Valid       (w_S1Valid),
        .o_S1Slot        (w_S1Slot),
        .o_Valid         (o_Valid),
        .o_VoiceOperator (o_VoiceOperator),
        .o_SampleStart   (o_SampleStart)
    );

    PhaseAcc_t      r_PhaseMem [NUM_VOICE_OPERATORS];
    FrequencyStep_t r_FreqMem  [NUM_VOICE_OPERATORS];
    logic [NUM_VOICE_OPERATORS-1:0] r_Pending;

    PhaseAcc_t      r_S1Acc;
    FrequencyStep_t r_S1Step;
    logic           r_S1Pending;
    logic           r_S1ReqHit;
    Phase_t         r_Phase;

    logic      w_Consume;
    PhaseAcc_t w_NextAcc;
    Phase_t    w_PhaseOut;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            if (i_FrequencyWriteEnable[0]) r_FreqMem[i_FrequencyWriteAddr][7:0]  <= i_FrequencyWriteData;
            if (i_FrequencyWriteEnable[1]) r_FreqMem[i_FrequencyWriteAddr][15:8] <= i_FrequencyWriteData;
        end
    end

    // Stage 1: registered reads; a request landing on the slot being read is
    // remembered so the later clear cannot swallow it.
    always_ff @(posedge i_Clock) begin
        r_S1Acc     <= r_PhaseMem[w_ReadSlot];
        r_S1Step    <= r_FreqMem[w_ReadSlot];
        r_S1Pending <= r_Pending[w_ReadSlot];
        r_S1ReqHit  <= !i_Reset && i_PhaseResetEnable && (i_PhaseResetAddr == w_ReadSlot);
    end

    always_comb begin
        w_Consume  = r_S1Pending;
        w_NextAcc  = r_S1Acc + f_ExtendStep(r_S1Step);
        w_PhaseOut = r_S1Acc[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
        if (w_Consume) begin
            w_NextAcc  = f_ExtendStep(r_S1Step);
            w_PhaseOut = '0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset && w_S1Valid) begin
            r_PhaseMem[w_S1Slot] <= w_NextAcc;
        end
    end

    // A set issued in the same cycle as the clear is ordered last so it wins.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Pending <= '1;
        end else begin
            if (w_S1Valid && r_S1Pending && !r_S1ReqHit) begin
                r_Pending[w_S1Slot] <= 1'b0;
            end
            if (i_PhaseResetEnable) begin
                r_Pending[i_PhaseResetAddr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Phase <= '0;
        end else begin
            r_Phase <= w_S1Valid ? w_PhaseOut : '0;
        end
    end

    assign o_Phase = r_Phase;

endmodule
`default_nettype wire

// File: tb/tb_stage_phase_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module    : tb_stage_phase_accumulator
//  Purpose   : Self-checking bench with a per-visit reference model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_stage_phase_accumulator;
    import stage_phase_accumulator_pkg::*;

    localparam int N = NUM_VOICE_OPERATORS;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       fwe;
    VoiceOperatorID_t faddr;
    logic [7:0]       fdata;
    logic             pre;
    VoiceOperatorID_t paddr;
    logic             o_valid;
    Phase_t           o_phase;
    VoiceOperatorID_t o_id;
    logic             o_ss;

    always #5 clk = ~clk;

    stage_phase_accumulator dut (
        .i_Clock                (clk),
        .i_Reset                (rst),
        .o_Valid                (o_valid),
        .o_Phase                (o_phase),
        .o_VoiceOperator        (o_id),
        .o_SampleStart          (o_ss),
        .i_FrequencyWriteEnable (fwe),
        .i_FrequencyWriteAddr   (faddr),
        .i_FrequencyWriteData   (fdata),
        .i_PhaseResetEnable     (pre),
        .i_PhaseResetAddr       (paddr)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: each visit of a slot either restarts it or emits
    // acc/256 and advances by its step; host writes land after that visit.
    typedef struct {
        int     id;
        int     phase;
        longint due;
    } exp_t;

    int unsigned m_acc  [N];
    int unsigned m_step [N];
    bit          m_pend [N];
    int          m_cnt = 0;
    longint      edge_no = 0;
    exp_t        expq[$];

    task automatic model_edge();
        exp_t e;
        if (rst) begin
            expq.delete();
            for (int i = 0; i < N; i++) m_pend[i] = 1'b1;
            m_cnt = 0;
            return;
        end
        e.id  = m_cnt;
        e.due = edge_no + 1;
        if (m_pend[m_cnt]) begin
            e.phase       = 0;
            m_acc[m_cnt]  = m_step[m_cnt];
            m_pend[m_cnt] = 1'b0;
        end else begin
            e.phase      = int'((m_acc[m_cnt] >> 8) & 32'hFFFF);
            m_acc[m_cnt] = (m_acc[m_cnt] + m_step[m_cnt]) % (1 << 24);
        end
        expq.push_back(e);
        if (fwe[0]) m_step[faddr] = (m_step[faddr] & 32'hFF00) | 32'(fdata);
        if (fwe[1]) m_step[faddr] = (m_step[faddr] & 32'h00FF) | (32'(fdata) << 8);
        if (pre) m_pend[paddr] = 1'b1;
        m_cnt = (m_cnt + 1) % N;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0; m_step[i] = 0; m_pend[i] = 1'b1;
        end
        forever begin
            @(posedge clk);
            edge_no++;
            model_edge();
        end
    end

    // Continuous scoreboard on the falling edge.
    initial begin
        exp_t e;
        bit   exp_v;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_v = (expq.size() > 0) && (expq[0].due == edge_no);
                check("model_valid", 32'(o_valid), 32'(exp_v));
                if (exp_v) begin
                    e = expq.pop_front();
                    check("model_id", 32'(o_id), 32'(e.id));
                    check("model_phase", 32'(o_phase), 32'(e.phase));
                    check("model_sstart", 32'(o_ss), 32'(e.id == 0));
                end else begin
                    check("model_sstart_idle", 32'(o_ss), 32'd0);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        fwe = 2'b00; faddr = '0; fdata = 8'h00; pre = 1'b0; paddr = '0;
    endtask

    task automatic write_step(input int slot, input logic [7:0] hi, input logic [7:0] lo);
        faddr = VoiceOperatorID_t'(slot);
        fwe = 2'b10; fdata = hi; tick();
        fwe = 2'b01; fdata = lo; tick();
        fwe = 2'b00; fdata = 8'hAA; tick();
        idle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1; tick();
        rst = 1'b0;
    endtask

    // Waits for the given visit index of a slot; returns its phase.
    task automatic wait_visit(input int slot, input int visit, output bit ok, output Phase_t ph);
        int seen = 0;
        ok = 1'b0; ph = '0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            tick();
            if (o_valid && o_id == VoiceOperatorID_t'(slot)) begin
                if (seen == visit) begin
                    ok = 1'b1; ph = o_phase;
                end
                seen++;
            end
        end
    endtask

    typedef struct {
        int         slot;
        logic [7:0] hi;
        logic [7:0] lo;
        int         visit;
        logic [15:0] expect_phase;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit     ok;
        Phase_t ph;

        vecs[0] = '{3, 8'h01, 8'h00, 0,   16'h0000};
        vecs[1] = '{3, 8'h01, 8'h00, 4,   16'h0004};
        vecs[2] = '{5, 8'hFF, 8'hFF, 1,   16'h00FF};
        vecs[3] = '{5, 8'hFF, 8'hFF, 2,   16'h01FF};
        vecs[4] = '{5, 8'hFF, 8'hFF, 257, 16'h00FE};
        vecs[5] = '{7, 8'h12, 8'h34, 1,   16'h0012};
        vecs[6] = '{7, 8'h12, 8'h34, 3,   16'h0036};
        vecs[7] = '{7, 8'h12, 8'h34, 0,   16'h0000};

        rst = 1'b1; idle();
        repeat (3) tick();
        rst = 1'b0;
        for (int s = 0; s < N; s++) begin
            fwe = 2'b11; faddr = VoiceOperatorID_t'(s); fdata = 8'h00; tick();
        end
        idle();
        rst = 1'b1; tick();
        chk_en = 1'b1;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_phase", 32'(o_phase), 32'd0);
        check("reset_id", 32'(o_id), 32'd0);
        check("reset_sstart", 32'(o_ss), 32'd0);
        tick();

        // First sweep after release: valid on the 3rd cycle, all phases zero.
        rst = 1'b0;
        tick();
        check("first_valid_c2", 32'(o_valid), 32'd0);
        tick();
        check("first_valid_c3", 32'(o_valid), 32'd1);
        check("first_id0", 32'(o_id), 32'd0);
        check("first_sstart", 32'(o_ss), 32'd1);
        for (int i = 1; i <= N; i++) begin
            tick();
            check("sweep_id", 32'(o_id), 32'(i % N));
            check("sweep_phase0", 32'(o_phase), 32'd0);
        end

        foreach (vecs[v]) begin
            write_step(vecs[v].slot, vecs[v].hi, vecs[v].lo);
            pulse_reset();
            wait_visit(vecs[v].slot, vecs[v].visit, ok, ph);
            check("vec_reached", 32'(ok), 32'd1);
            check("vec_phase", 32'(ph), 32'(vecs[v].expect_phase));
        end

        // Phase reset, including a second request in the consume cycle.
        write_step(2, 8'h03, 8'h00);
        pulse_reset();
        wait_visit(2, 3, ok, ph);
        check("prst_reached", 32'(ok), 32'd1);
        check("prst_before", 32'(ph), 32'h0009);
        pre = 1'b1; paddr = VoiceOperatorID_t'(2); tick();
        pre = 1'b0;
        repeat (N - 2) tick();
        pre = 1'b1; tick();
        pre = 1'b0;
        check("prst_id1", 32'(o_id), 32'd2);
        check("prst_zero1", 32'(o_phase), 32'd0);
        repeat (N) tick();
        check("prst_id2", 32'(o_id), 32'd2);
        check("prst_zero2", 32'(o_phase), 32'd0);
        repeat (N) tick();
        check("prst_step", 32'(o_phase), 32'h0003);

        // Reset while the counter sits at N/2 (output lags by two slots).
        wait_visit(N / 2 - 2, 0, ok, ph);
        check("mid_reached", 32'(ok), 32'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        check("mid_valid_a", 32'(o_valid), 32'd0);
        tick();
        check("mid_valid_b", 32'(o_valid), 32'd0);
        for (int i = 0; i < N; i++) begin
            tick();
            check("mid_valid", 32'(o_valid), 32'd1);
            check("mid_id", 32'(o_id), 32'(i));
            check("mid_phase0", 32'(o_phase), 32'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            fwe   = 2'($urandom_range(0, 3));
            faddr = VoiceOperatorID_t'($urandom_range(0, N - 1));
            fdata = 8'($urandom);
            pre   = ($urandom_range(0, 7) == 0);
            paddr = VoiceOperatorID_t'($urandom_range(0, N - 1));
            rst   = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; idle();
        repeat (2 * N) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
